// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared GPS datapath types and ASCII constants
package gps_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop metastability synchroniser
// Reset value is a parameter so an idle-high serial line stays quiet through reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gps_uart_rx.sv
// rtl/gps_uart_rx.sv - 8N1 LSB-first serial receiver feeding the GPS parser
// Samples each bit at its centre; returns to IDLE at mid-stop-bit so back-to-back bytes are caught.
module gps_uart_rx
    import gps_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx_serial,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("gps_uart_rx: CLKS_PER_BIT must be >= 4");
    end

    logic                 w_rx_s;
    rx_state_t            r_state, w_next_state;
    logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic [7:0]           r_shift, w_shift_next;
    logic [7:0]           r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_ferr, w_ferr_next;
    logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_next;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx_serial),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
            r_err_cnt <= w_err_cnt_next;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_ferr_next    = 1'b0;
        w_err_cnt_next = r_err_cnt;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next_state   = START;
                    w_clk_cnt_next = '0;
                end
            end
            START: begin
                // A line that is high again at mid-start-bit was only a glitch.
                if (r_clk_cnt == CNT_HALF) begin
                    if (w_rx_s) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state   = DATA;
                        w_clk_cnt_next = '0;
                        w_bit_idx_next = '0;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_next          = '0;
                    w_shift_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_next_state = WAIT_IDLE;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_next = r_err_cnt + ERR_CNT_W'(1);
                        end
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low break must not re-trigger; wait for the line to recover.
                if (w_rx_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);
    assign o_err_count = r_err_cnt;

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb/tb_gps_uart_rx.sv - self-checking bench for gps_uart_rx
module tb_gps_uart_rx;
    import gps_pkg::*;

    localparam int CPB  = 87;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 4 + HALF + 9 * CPB;
    localparam int CPB2 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] o_data, o_data2, o_err, o_err2;
    logic       o_valid, o_ferr, o_busy, o_valid2, o_ferr2, o_busy2;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int valid2_cnt = 0;
    int ferr2_cnt = 0;

    typedef struct {
        int         t;
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold_low;
        logic       exp_ferr;
        logic [7:0] exp_data;
        logic [7:0] exp_err;
    } vec_t;

    ev_t exp_q[$];
    ev_t act_q[$];
    logic [7:0] model_last = 8'h00;
    int         model_err = 0;

    gps_uart_rx #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_serial (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_ferr),
        .o_busy      (o_busy),
        .o_err_count (o_err)
    );

    gps_uart_rx #(.CLKS_PER_BIT(CPB2), .ERR_CNT_W(8)) u_dut_fast (
        .clk         (clk),
        .rst         (rst),
        .i_rx_serial (rx2),
        .o_data      (o_data2),
        .o_valid     (o_valid2),
        .o_frame_err (o_ferr2),
        .o_busy      (o_busy2),
        .o_err_count (o_err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if ((o_valid && o_ferr) || (o_valid2 && o_ferr2)) begin
                miscompares++;
                $display("FAIL valid_ferr_overlap: both pulses high at cycle %0d, required never", cyc);
            end
            if (o_valid || o_ferr) begin
                act_q.push_back('{t: cyc, ferr: o_ferr, data: o_data});
            end
            if (o_valid2) valid2_cnt++;
            if (o_ferr2)  ferr2_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: one event per frame, LAT cycles after the start edge, carrying the last good byte.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t e;
        e.t    = cyc + LAT;
        e.ferr = !stop;
        if (stop) begin
            e.data     = b;
            model_last = b;
        end else begin
            e.data = model_last;
            if (model_err < 255) model_err++;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic check_events(input string tag);
        while (exp_q.size() > 0) begin
            ev_t e;
            ev_t a;
            e = exp_q.pop_front();
            vectors++;
            if (act_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s missing_event: got none, required ferr=%0b data=%02h near cycle %0d",
                         tag, e.ferr, e.data, e.t);
            end else begin
                a = act_q.pop_front();
                if (a.ferr !== e.ferr || a.data !== e.data || a.t < e.t - 1 || a.t > e.t + 1) begin
                    miscompares++;
                    $display("FAIL %s event: got ferr=%0b data=%02h cycle=%0d, required ferr=%0b data=%02h cycle=%0d(+/-1)",
                             tag, a.ferr, a.data, a.t, e.ferr, e.data, e.t);
                end
            end
        end
        check({tag, "_extra_events"}, act_q.size(), 0);
        act_q.delete();
    endtask

    task automatic send2(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx2 = frame[i];
            repeat (CPB2) @(posedge clk);
            #1;
        end
        rx2 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    logic [7:0] gga[7];

    initial begin
        tbl[0] = '{8'h24, 1'b1,   0, 1'b0, 8'h24, 8'd0};
        tbl[1] = '{8'h00, 1'b1,   0, 1'b0, 8'h00, 8'd0};
        tbl[2] = '{8'hFF, 1'b1,   0, 1'b0, 8'hFF, 8'd0};
        tbl[3] = '{8'hA5, 1'b1,   0, 1'b0, 8'hA5, 8'd0};
        tbl[4] = '{8'h47, 1'b0, 500, 1'b1, 8'hA5, 8'd1};
        tbl[5] = '{8'h41, 1'b1,   0, 1'b0, 8'h41, 8'd1};
        tbl[6] = '{8'h2C, 1'b1,   0, 1'b0, 8'h2C, 8'd1};
        tbl[7] = '{8'h55, 1'b0,   0, 1'b1, 8'h2C, 8'd2};
        tbl[8] = '{8'h80, 1'b1,   0, 1'b0, 8'h80, 8'd2};
        tbl[9] = '{8'h01, 1'b1,   0, 1'b0, 8'h01, 8'd2};
        gga    = '{ASCII_DOLLAR, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41, ASCII_COMMA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_o_data", o_data, 0);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_frame_err", o_ferr, 0);
        check("reset_o_busy", o_busy, 0);
        check("reset_o_err_count", o_err, 0);
        check("reset_fast_err_count", o_err2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Short low glitch: rejected at mid-start-bit.
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle(10);
        check("glitch_busy_during", o_busy, 1);
        idle(60);
        check("glitch_busy_after", o_busy, 0);
        check("glitch_err_count", o_err, 0);
        check_events("glitch");

        for (int i = 0; i < 10; i++) begin
            logic pk;
            send_frame(tbl[i].data, tbl[i].stop);
            if (tbl[i].hold_low > 0) begin
                rx = 1'b0;
                repeat (tbl[i].hold_low / 2) @(posedge clk);
                #1;
                check("break_busy", o_busy, 1);
                check("break_err_count", o_err, tbl[i].exp_err);
                repeat (tbl[i].hold_low - tbl[i].hold_low / 2) @(posedge clk);
                #1;
            end
            idle(20);
            pk = (act_q.size() > 0) ? act_q[0].ferr : 1'bx;
            check($sformatf("tbl%0d_ferr", i), pk, tbl[i].exp_ferr);
            check_events($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_o_data", i), o_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_err_count", i), o_err, tbl[i].exp_err);
            check($sformatf("tbl%0d_busy", i), o_busy, 0);
        end

        // NMEA header with zero idle time between frames.
        for (int i = 0; i < 7; i++) send_frame(gga[i], 1'b1);
        idle(20);
        check_events("gga_b2b");
        check("gga_o_data", o_data, ASCII_COMMA);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            idle($urandom_range(stop ? 0 : 2, 25));
        end
        idle(20);
        check_events("random");
        check("random_err_count", o_err, model_err);
        check("random_o_data", o_data, model_last);

        // Reset in the middle of 8'h55; the sender is abandoned along with it.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_o_valid", o_valid, 0);
            check("rst_hold_o_busy", o_busy, 0);
        end
        check("rst_hold_o_data", o_data, 0);
        check("rst_hold_o_frame_err", o_ferr, 0);
        check("rst_hold_o_err_count", o_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 8'h00;
        model_err  = 0;
        idle(50);
        send_frame(8'h2C, 1'b1);
        idle(20);
        check_events("post_reset");
        check("post_reset_o_data", o_data, 8'h2C);
        check("post_reset_err_count", o_err, 0);

        // Saturation on the minimum-CLKS_PER_BIT instance.
        valid2_cnt = 0;
        ferr2_cnt  = 0;
        for (int i = 0; i < 300; i++) begin
            send2(8'($urandom_range(0, 255)), 1'b0);
            if (i == 253) check("fast_err_at_254", o_err2, 254);
            if (i == 254) check("fast_err_at_255", o_err2, 255);
        end
        check("fast_err_saturated", o_err2, 255);
        check("fast_ferr_pulses", ferr2_cnt, 300);
        check("fast_no_valid", valid2_cnt, 0);
        send2(8'hA5, 1'b1);
        check("fast_good_valid", valid2_cnt, 1);
        check("fast_good_data", o_data2, 8'hA5);
        check("fast_err_hold", o_err2, 255);
        check("fast_busy_idle", o_busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
